borrow_select_subtractor_seq: RTL and testbench

//  Multi-cycle WIDTH-bit subtractor: diff = a - b - bin, one SLICE-bit borrow-select slice per clock.

---
 rtl/borrow_select_subtractor_seq_if.sv | 38 +++
 rtl/borrow_select_subtractor_seq.sv | 121 ++++++++++++
 tb/tb_borrow_select_subtractor_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/borrow_select_subtractor_seq_if.sv
// Operand/result bundle for the sequential borrow-select subtractor.
// The zero output exists only when ZERO_FLAG_EN is defined.
interface borrow_select_subtractor_seq_if #(
  parameter int WIDTH = 16
);
  // Valid/ready handshake on both sides: a transfer happens on a rising clock
  // edge where valid && ready are both 1. A producer holds valid and its data
  // steady until that edge. A consumer may change ready at any time.
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
`ifdef ZERO_FLAG_EN
  logic             zero;
`endif

  modport master (
    output start_valid, a, b, bin, done_ready,
    input  start_ready, done_valid, diff, bout, ovf
`ifdef ZERO_FLAG_EN
    , input zero
`endif
  );

  modport slave (
    input  start_valid, a, b, bin, done_ready,
    output start_ready, done_valid, diff, bout, ovf
`ifdef ZERO_FLAG_EN
    , output zero
`endif
  );
endinterface

// File: rtl/borrow_select_subtractor_seq.sv
// Multi-cycle subtractor diff = a - b - bin, one SLICE-bit borrow-select slice per clock.
// Optional feature macro ZERO_FLAG_EN adds a registered zero flag on the result side.
module borrow_select_subtractor_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  borrow_select_subtractor_seq_if.slave bus,
  output logic [1:0]                    dbg_state
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % SLICE) != 0 || SLICE < 1) begin : g_bad_cfg
    $error("WIDTH must be a non-zero multiple of SLICE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             fin;
  logic             borrow_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [SLICE-1:0] diff_sl [N];
  logic [WIDTH-1:0] diff_w;
  logic             bout_r;
  logic             ovf_r;
  logic             zero_r;

  logic [SLICE-1:0] a_sl [N];
  logic [SLICE-1:0] b_sl [N];
  logic [SLICE:0]   s0;
  logic [SLICE:0]   s1;
  logic [SLICE:0]   sel;

  for (genvar k = 0; k < N; k++) begin : g_slice
    assign a_sl[k] = a_r[k*SLICE +: SLICE];
    assign b_sl[k] = b_r[k*SLICE +: SLICE];
    assign diff_w[k*SLICE +: SLICE] = diff_sl[k];
  end

  // Both candidates are formed one bit wider; the top bit is the slice borrow-out.
  always_comb begin
    s0  = {1'b0, a_sl[cnt]} - {1'b0, b_sl[cnt]};
    s1  = {1'b0, a_sl[cnt]} - {1'b0, b_sl[cnt]} - {{SLICE{1'b0}}, 1'b1};
    sel = borrow_r ? s1 : s0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      fin      <= 1'b0;
      borrow_r <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      bout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b0;
      for (int k = 0; k < N; k++) diff_sl[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            a_r      <= bus.a;
            b_r      <= bus.b;
            borrow_r <= bus.bin;
            cnt      <= '0;
            fin      <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          // After the last slice lands, one more cycle derives the flags from the full diff.
          if (fin) begin
            ovf_r  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_w[WIDTH-1] != a_r[WIDTH-1]);
            zero_r <= (diff_w == '0);
            fin    <= 1'b0;
            cnt    <= '0;
            state  <= DONE;
          end else begin
            diff_sl[cnt] <= sel[SLICE-1:0];
            borrow_r     <= sel[SLICE];
            if (cnt == LAST) begin
              bout_r <= sel[SLICE];
              fin    <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.done_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.start_ready = (state == IDLE);
  assign bus.done_valid  = (state == DONE);
  assign bus.diff        = diff_w;
  assign bus.bout        = bout_r;
  assign bus.ovf         = ovf_r;
  assign dbg_state       = state;

`ifdef ZERO_FLAG_EN
  assign bus.zero = zero_r;
`else
  logic unused_zero;
  assign unused_zero = zero_r;
`endif
endmodule

// File: tb/tb_borrow_select_subtractor_seq.sv
// Scoreboard bench for borrow_select_subtractor_seq: directed corner cases plus random operands.
// Checks the zero flag too when ZERO_FLAG_EN is defined.
module tb_borrow_select_subtractor_seq;
  localparam int W   = 16;
  localparam int LAT = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         cyc = 0;

  borrow_select_subtractor_seq_if #(.WIDTH(W)) bus ();

  borrow_select_subtractor_seq #(.WIDTH(W), .SLICE(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state: {zero, bout, ovf, diff}
  logic [W+2:0] exp_q[$];
  int           lat_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           stall_left = 0;
  bit           ready_rand = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int unsigned av, bv, bi, d;
    logic [31:0] dv;
    logic [W-1:0] dd;
    logic bo, ov, z;
    av = a; bv = b; bi = bin;
    d  = (av + 65536 - bv - bi) % 65536;
    dv = d;
    dd = dv[W-1:0];
    bo = (av < bv + bi);
    ov = (a[W-1] != b[W-1]) && (dd[W-1] != a[W-1]);
    z  = (dd == '0);
    return {z, bo, ov, dd};
  endfunction

  // driver: present operands, wait for acceptance, then scramble the bus
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int  guard;
    bit  hs;
    @(posedge clk); #1;
    bus.start_valid = 1'b1;
    bus.a = a; bus.b = b; bus.bin = bin;
    guard = 0;
    hs = 1'b0;
    while (!hs && guard < 200) begin
      @(negedge clk);
      hs = bus.start_ready;
      guard++;
    end
    if (!hs) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.start_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(a, b, bin));
    @(posedge clk); #1;
    lat_q.push_back(cyc);
    bus.start_valid = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q.size() != 0 || !bus.start_ready) && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // consumer ready: optional forced stall, then random or always-ready
  initial begin
    bus.done_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0 && bus.done_valid) begin
        bus.done_ready = 1'b0;
        stall_left--;
      end else if (ready_rand) begin
        bus.done_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.done_ready = 1'b1;
      end
    end
  end

  // monitor: hold checks, latency, and result compare on each done handshake
  initial begin
    bit          pv, pr;
    logic [W+1:0] prev, cur;
    logic [W+2:0] e;
    pv = 1'b0; pr = 1'b0; prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
        continue;
      end
      cur = {bus.bout, bus.ovf, bus.diff};
      if (pv && !pr) begin
        check("hold_done_valid", 32'(bus.done_valid), 32'd1);
        check("hold_result", 32'(cur), 32'(prev));
        check("hold_start_ready", 32'(bus.start_ready), 32'd0);
      end
      if (pv && pr) begin
        check("post_hs_start_ready", 32'(bus.start_ready), 32'd1);
        check("post_hs_done_valid", 32'(bus.done_valid), 32'd0);
      end
      if (bus.done_valid && !pv) begin
        if (lat_q.size() == 0) check("stray_done_valid", 32'd1, 32'd0);
        else check("latency", 32'(cyc - lat_q.pop_front()), 32'(LAT));
      end
      if (bus.done_valid && bus.done_ready) begin
        if (exp_q.size() == 0) begin
          check("stray_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("diff", 32'(bus.diff), 32'(e[W-1:0]));
          check("ovf", 32'(bus.ovf), 32'(e[W]));
          check("bout", 32'(bus.bout), 32'(e[W+1]));
`ifdef ZERO_FLAG_EN
          check("zero", 32'(bus.zero), 32'(e[W+2]));
`endif
        end
      end
      pv = bus.done_valid;
      pr = bus.done_ready;
      prev = cur;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    bus.start_valid = 1'b0;
    bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done_valid", 32'(bus.done_valid), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_bout", 32'(bus.bout), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
`ifdef ZERO_FLAG_EN
    check("rst_zero", 32'(bus.zero), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("start_ready_after_reset", 32'(bus.start_ready), 32'd1);

    // directed corner cases
    issue(16'h0005, 16'h0003, 1'b0); wait_drain();
    issue(16'h0000, 16'h0001, 1'b0); wait_drain();
    issue(16'h8000, 16'h0001, 1'b0); wait_drain();
    issue(16'hFFFF, 16'hFFFF, 1'b1); wait_drain();
    issue(16'h1234, 16'h1234, 1'b0); wait_drain();
    issue(16'h7FFF, 16'hFFFF, 1'b0); wait_drain();
    issue(16'h0000, 16'h0000, 1'b1); wait_drain();

    // random operands with random back-pressure
    ready_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
    end
    wait_drain();
    ready_rand = 1'b0;

    // sustained back-pressure for three cycles
    stall_left = 3;
    issue(16'hA5A5, 16'h5A5A, 1'b1);
    wait_drain();
    check("stall_consumed", 32'(stall_left), 32'd0);

    // reset during the second slice discards the operation
    issue(16'h4321, 16'h1234, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    check("midrun_rst_state", 32'(dbg_state), 32'd0);
    check("midrun_rst_done_valid", 32'(bus.done_valid), 32'd0);
    check("midrun_rst_diff", 32'(bus.diff), 32'd0);
    check("midrun_rst_start_ready", 32'(bus.start_ready), 32'd1);
    repeat (10) @(negedge clk);
    issue(16'h1000, 16'h0001, 1'b1);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
